crc5_codeword_serializer: RTL and testbench



---
 rtl/crc5_pkg.sv | 27 ++
 rtl/crc5_serial_lfsr.sv | 34 +++
 rtl/crc5_codeword_serializer.sv | 106 ++++++++++
 tb/tb_crc5_codeword_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/crc5_pkg.sv
// rtl/crc5_pkg.sv - shared widths, generator, FSM state and reference remainder for the CRC-5 serializer
package crc5_pkg;

   localparam int MSG_W = 6;
   localparam int CRC_W = 5;
   localparam int FRAME = MSG_W + CRC_W;
   // Low-order coefficients of g(y)=1+y+y^3+y^5; the y^5 term is implicit.
   localparam logic [CRC_W-1:0] POLY = 5'b01011;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Remainder of msg(y)*y^CRC_W mod g(y), i.e. the systematic check bits.
   function automatic logic [CRC_W-1:0] crc5_ref(input logic [MSG_W-1:0] msg);
      logic [CRC_W-1:0] rem;
      logic             fb;
      rem = '0;
      for (int i = MSG_W - 1; i >= 0; i--) begin
         fb  = msg[i] ^ rem[CRC_W-1];
         rem = {rem[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return rem;
   endfunction

endpackage

// File: rtl/crc5_serial_lfsr.sv
// rtl/crc5_serial_lfsr.sv - bit-serial divider by g(y); state is zero after a valid codeword
module crc5_serial_lfsr
   import crc5_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] state
);

   logic [CRC_W-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = '0;
      end else if (en) begin
         state_d = {state_q[CRC_W-2:0], din} ^ (state_q[CRC_W-1] ? POLY : '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/crc5_codeword_serializer.sv
// rtl/crc5_codeword_serializer.sv - serializes {msg, crc} MSB first; CRC5_SELFCHECK_EN adds crc_err
module crc5_codeword_serializer
   import crc5_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [MSG_W-1:0] msg_in,
   input  logic [CRC_W-1:0] crc_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic             busy
`ifdef CRC5_SELFCHECK_EN
   ,
   output logic             crc_err
`endif
);

   state_e           state_q, state_d;
   logic [FRAME-1:0] shreg_q, shreg_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             last_w;
   logic             load_w;
   logic             xfer_w;

   assign last_w = (cnt_q == 4'(FRAME - 1));
   assign load_w = (state_q == IDLE) && in_valid;
   assign xfer_w = (state_q == SHIFT) && ser_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (ser_ready && last_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend on registered state only, never on in_valid.
   always_comb begin
      in_ready  = (state_q == IDLE);
      ser_valid = (state_q == SHIFT);
      busy      = (state_q == SHIFT);
      ser_out   = (state_q == SHIFT) && shreg_q[FRAME-1];
      ser_last  = (state_q == SHIFT) && last_w;
   end

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_w) begin
         shreg_d = {msg_in, crc_in};
         cnt_d   = '0;
      end else if (xfer_w) begin
         shreg_d = {shreg_q[FRAME-2:0], 1'b0};
         cnt_d   = last_w ? 4'd0 : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef CRC5_SELFCHECK_EN
   logic [CRC_W-1:0] lfsr_state;
   logic             chk_pend_q;

   crc5_serial_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .clr   (load_w),
      .en    (xfer_w),
      .din   (shreg_q[FRAME-1]),
      .state (lfsr_state)
   );

   // The divider settles on the edge of the last transfer; judge it the cycle after.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chk_pend_q <= 1'b0;
      end else begin
         chk_pend_q <= xfer_w && last_w;
      end
   end

   assign crc_err = chk_pend_q && (lfsr_state != '0);
`endif

endmodule

// File: tb/tb_crc5_codeword_serializer.sv
// tb/tb_crc5_codeword_serializer.sv - randomized self-checking bench with a polynomial-division reference
module tb_crc5_codeword_serializer;
   import crc5_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic [MSG_W-1:0] msg_in;
   logic [CRC_W-1:0] crc_in;
   logic             in_valid;
   logic             in_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_last;
   logic             busy;
`ifdef CRC5_SELFCHECK_EN
   logic             crc_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   crc5_codeword_serializer dut (
      .clk       (clk),
      .reset     (reset),
      .msg_in    (msg_in),
      .crc_in    (crc_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .ser_last  (ser_last),
      .busy      (busy)
`ifdef CRC5_SELFCHECK_EN
      ,
      .crc_err   (crc_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Long division of an 11-bit codeword polynomial by g(y)=y^5+y^3+y+1.
   function automatic logic [CRC_W-1:0] mod_g(input logic [FRAME-1:0] cw);
      logic [FRAME-1:0] r;
      logic [FRAME-1:0] g;
      r = cw;
      g = FRAME'(6'b101011);
      for (int i = FRAME - 1; i >= CRC_W; i--)
         if (r[i]) r = r ^ (g << (i - CRC_W));
      return r[CRC_W-1:0];
   endfunction

   // Called at a falling edge while idle. mode: 0 ready high, 1 toggling, 2 random.
   // abort_at >= 0 asserts reset while that bit index is presented.
   task automatic send_frame(input logic [MSG_W-1:0] m, input logic [CRC_W-1:0] c,
                             input int mode, input bit keep_valid, input int abort_at);
      logic [FRAME-1:0] cw;
      int               idx;
      int               cyc;
      logic             pr_out;
      logic             pr_last;
      bit               stalled;
      bit               exp_err;
      cw      = {m, c};
      idx     = 0;
      cyc     = 0;
      pr_out  = 1'b0;
      pr_last = 1'b0;
      stalled = 1'b0;
      exp_err = (mod_g(cw) != '0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_ser_valid", 32'(ser_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      msg_in   = m;
      crc_in   = c;
      in_valid = 1'b1;
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      while (idx < FRAME && cyc < 200) begin
         if (idx == abort_at) begin
            reset = 1'b1;
            #1;
            chk("rst_ser_valid", 32'(ser_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_ser_last", 32'(ser_last), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (mode == 0)      ser_ready = 1'b1;
         else if (mode == 1) ser_ready = (cyc % 2 == 0);
         else                ser_ready = 1'($urandom_range(0, 1));
         chk("shift_valid", 32'(ser_valid), 32'd1);
         chk("shift_in_ready", 32'(in_ready), 32'd0);
         chk("shift_busy", 32'(busy), 32'd1);
         chk("last_flag", 32'(ser_last), 32'(idx == FRAME - 1));
         if (stalled) begin
            chk("hold_out", 32'(ser_out), 32'(pr_out));
            chk("hold_last", 32'(ser_last), 32'(pr_last));
         end
         pr_out  = ser_out;
         pr_last = ser_last;
         stalled = !ser_ready;
         if (ser_ready) begin
            chk("bit", 32'(ser_out), 32'(cw[FRAME-1-idx]));
            idx++;
         end
         cyc++;
         @(negedge clk);
      end
      chk("timeout", 32'(cyc < 200), 32'd1);
      if (mode == 0) chk("latency", 32'(cyc), 32'(FRAME));
      ser_ready = 1'b0;
      chk("end_ser_valid", 32'(ser_valid), 32'd0);
      chk("end_in_ready", 32'(in_ready), 32'd1);
`ifdef CRC5_SELFCHECK_EN
      chk("crc_err", 32'(crc_err), 32'(exp_err));
`else
      if (exp_err) total = total + 0;
`endif
   endtask

   initial begin
      logic [MSG_W-1:0] m;
      reset     = 1'b1;
      in_valid  = 1'b0;
      ser_ready = 1'b0;
      msg_in    = '0;
      crc_in    = '0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ser_valid", 32'(ser_valid), 32'd0);
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_ser_last", 32'(ser_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef CRC5_SELFCHECK_EN
      chk("rst_crc_err", 32'(crc_err), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("ref_100000", 32'(crc5_ref(6'b100000)), 32'h13);
      chk("ref_000001", 32'(crc5_ref(6'b000001)), 32'h0b);

      send_frame(6'b100000, 5'b10011, 0, 1'b0, -1);
      send_frame(6'b000001, 5'b01011, 1, 1'b0, -1);

      send_frame(6'b100000, 5'b10010, 0, 1'b0, -1);
`ifdef CRC5_SELFCHECK_EN
      @(negedge clk);
      chk("err_one_cycle", 32'(crc_err), 32'd0);
`endif

      m = 6'($urandom);
      send_frame(m, crc5_ref(m), 0, 1'b1, -1);
      send_frame(m, crc5_ref(m), 0, 1'b1, -1);
      in_valid = 1'b0;
      @(negedge clk);

      m = 6'($urandom);
      send_frame(m, crc5_ref(m), 0, 1'b0, 4);
      m = 6'($urandom);
      send_frame(m, crc5_ref(m), 0, 1'b0, -1);

      for (int i = 0; i < 64; i++) begin
         m = 6'(i);
         chk("ref_fn", 32'(crc5_ref(m)), 32'(mod_g({m, 5'b00000})));
         send_frame(m, crc5_ref(m), 2, 1'b0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
